// File: rtl/fetch_predict.sv
`default_nettype none
// ============================================================================
// Module      : fetch_predict
// Description : Fetch stage and IF/ID pipeline register. Holds the PC,
//               drives the instruction-memory address, looks up a 2-bit
//               saturating branch history table and applies redirects from
//               decode (predicted taken) and execute (mispredict).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_predict #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_BITS  = 6,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PCF,
    input  logic [31:0] InstrF,
    input  logic        imem_ready,
    input  logic        StallD,
    input  logic        pc_predict_redirect_D,
    input  logic [31:0] predicted_target_pc_D,
    input  logic        mispredict_E,
    input  logic [31:0] correct_pc_E,
    input  logic        bht_update_E,
    input  logic [31:0] bht_pc_E,
    input  logic        bht_taken_E,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        predict_taken_D
);

    localparam int         c_BHT_DEPTH = 1 << BHT_BITS;
    localparam logic [1:0] c_WEAK_NT   = 2'b01;

    logic [31:0]         r_pcf;
    logic [31:0]         r_instr_d;
    logic [31:0]         r_pc_d;
    logic [31:0]         r_pc_plus4_d;
    logic                r_pred_d;
    logic [1:0]          r_bht [c_BHT_DEPTH];

    logic [31:0]         w_pc_plus4;
    logic [BHT_BITS-1:0] w_fetch_idx;
    logic [BHT_BITS-1:0] w_train_idx;
    logic [1:0]          w_train_old;
    logic                w_fetch_pred;

    // PC[1:0] is ignored; the table is indexed by the word address bits.
    assign w_pc_plus4   = r_pcf + 32'd4;
    assign w_fetch_idx  = r_pcf[BHT_BITS+1:2];
    assign w_train_idx  = bht_pc_E[BHT_BITS+1:2];
    assign w_train_old  = r_bht[w_train_idx];
    assign w_fetch_pred = r_bht[w_fetch_idx][1];

    assign PCF             = r_pcf;
    assign InstrD          = r_instr_d;
    assign PCD             = r_pc_d;
    assign PCPlus4D        = r_pc_plus4_d;
    assign predict_taken_D = r_pred_d;

    // PC and IF/ID register: mispredict > stall > decode redirect > imem wait > advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcf        <= RESET_PC;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_pred_d     <= 1'b0;
        end else if (mispredict_E) begin
            r_pcf        <= correct_pc_E;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_pred_d     <= 1'b0;
        end else if (StallD) begin
            // Hold everything; a pending decode redirect is re-presented after the stall.
            r_pcf        <= r_pcf;
        end else if (pc_predict_redirect_D) begin
            // The instruction fetched this cycle is the wrong-path PC+4: squash it.
            r_pcf        <= predicted_target_pc_D;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_pred_d     <= 1'b0;
        end else if (!imem_ready) begin
            r_pcf        <= r_pcf;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_pred_d     <= 1'b0;
        end else begin
            r_pcf        <= w_pc_plus4;
            r_instr_d    <= InstrF;
            r_pc_d       <= r_pcf;
            r_pc_plus4_d <= w_pc_plus4;
            r_pred_d     <= w_fetch_pred;
        end
    end

    // BHT training: saturating 2-bit counters; lookup this cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_BHT_DEPTH; i++) begin
                r_bht[i] <= c_WEAK_NT;
            end
        end else if (bht_update_E) begin
            if (bht_taken_E) begin
                if (w_train_old != 2'b11) begin
                    r_bht[w_train_idx] <= w_train_old + 2'b01;
                end
            end else begin
                if (w_train_old != 2'b00) begin
                    r_bht[w_train_idx] <= w_train_old - 2'b01;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_predict.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_predict
// Description : Directed self-checking bench for fetch_predict.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_predict;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        imem_ready;
    logic        StallD;
    logic        pc_predict_redirect_D;
    logic [31:0] predicted_target_pc_D;
    logic        mispredict_E;
    logic [31:0] correct_pc_E;
    logic        bht_update_E;
    logic [31:0] bht_pc_E;
    logic        bht_taken_E;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        predict_taken_D;

    int r_tests;
    int r_fails;

    fetch_predict dut (
        .clk                   (clk),
        .rst                   (rst),
        .PCF                   (PCF),
        .InstrF                (InstrF),
        .imem_ready            (imem_ready),
        .StallD                (StallD),
        .pc_predict_redirect_D (pc_predict_redirect_D),
        .predicted_target_pc_D (predicted_target_pc_D),
        .mispredict_E          (mispredict_E),
        .correct_pc_E          (correct_pc_E),
        .bht_update_E          (bht_update_E),
        .bht_pc_E              (bht_pc_E),
        .bht_taken_E           (bht_taken_E),
        .InstrD                (InstrD),
        .PCD                   (PCD),
        .PCPlus4D              (PCPlus4D),
        .predict_taken_D       (predict_taken_D)
    );

    // Instruction memory model: each word encodes its own address.
    assign InstrF = 32'hA000_0000 | PCF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_tests++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst                   = 1'b0;
        imem_ready            = 1'b1;
        StallD                = 1'b0;
        pc_predict_redirect_D = 1'b0;
        predicted_target_pc_D = 32'd0;
        mispredict_E          = 1'b0;
        correct_pc_E          = 32'd0;
        bht_update_E          = 1'b0;
        bht_pc_E              = 32'd0;
        bht_taken_E           = 1'b0;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_instr"}, InstrD, c_NOP);
        check({tag, "_pcd"}, PCD, 32'd0);
        check({tag, "_pc4d"}, PCPlus4D, 32'd0);
        check({tag, "_pred"}, {31'd0, predict_taken_D}, 32'd0);
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic pred);
        check({tag, "_instr"}, InstrD, 32'hA000_0000 | pc);
        check({tag, "_pcd"}, PCD, pc);
        check({tag, "_pc4d"}, PCPlus4D, pc + 32'd4);
        check({tag, "_pred"}, {31'd0, predict_taken_D}, {31'd0, pred});
    endtask

    task automatic redirect_e(input logic [31:0] pc);
        mispredict_E = 1'b1;
        correct_pc_E = pc;
        tick();
        mispredict_E = 1'b0;
    endtask

    initial begin
        r_tests = 0;
        r_fails = 0;
        idle();

        // T1: reset and sequential fetch
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t1_rst_pcf", PCF, 32'd0);
        check_bubble("t1_rst");
        tick();
        check("t1_pcf4", PCF, 32'd4);
        check_id("t1_id0", 32'd0, 1'b0);
        tick();
        check("t1_pcf8", PCF, 32'd8);
        check_id("t1_id4", 32'd4, 1'b0);

        // T2: train PC 0xC taken twice while held at reset PC
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        StallD       = 1'b1;
        bht_update_E = 1'b1;
        bht_pc_E     = 32'h0000_000C;
        bht_taken_E  = 1'b1;
        tick();
        tick();
        idle();
        check("t2_held_pcf", PCF, 32'd0);
        tick();
        tick();
        tick();
        check("t2_pcf_c", PCF, 32'h0000_000C);
        tick();
        check_id("t2_id_c", 32'h0000_000C, 1'b1);
        pc_predict_redirect_D = 1'b1;
        predicted_target_pc_D = 32'h0000_0040;
        tick();
        pc_predict_redirect_D = 1'b0;
        check("t2_redir_pcf", PCF, 32'h0000_0040);
        check_bubble("t2_redir");
        tick();
        check_id("t2_id_40", 32'h0000_0040, 1'b0);

        // T3: mispredict beats stall and decode redirect
        mispredict_E          = 1'b1;
        correct_pc_E          = 32'h0000_0100;
        StallD                = 1'b1;
        pc_predict_redirect_D = 1'b1;
        predicted_target_pc_D = 32'h0000_0200;
        tick();
        idle();
        check("t3_pcf", PCF, 32'h0000_0100);
        check_bubble("t3");
        tick();
        check("t3_pcf_next", PCF, 32'h0000_0104);
        check_id("t3_id", 32'h0000_0100, 1'b0);

        // T4: stall holds all state; redirect acted on only after stall drops
        StallD                = 1'b1;
        pc_predict_redirect_D = 1'b1;
        predicted_target_pc_D = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_stall_pcf", PCF, 32'h0000_0104);
            check_id("t4_stall_id", 32'h0000_0100, 1'b0);
        end
        StallD = 1'b0;
        tick();
        pc_predict_redirect_D = 1'b0;
        check("t4_redir_pcf", PCF, 32'h0000_0300);
        check_bubble("t4_redir");
        tick();
        check_id("t4_id", 32'h0000_0300, 1'b0);

        // T5a: 5 taken then 1 not-taken on PC 0x20 -> 3 then 2, predicts taken
        bht_update_E = 1'b1;
        bht_pc_E     = 32'h0000_0020;
        bht_taken_E  = 1'b1;
        redirect_e(32'h0000_0020);
        StallD = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bht_taken_E = 1'b0;
        tick();
        idle();
        check("t5_held_pcf", PCF, 32'h0000_0020);
        tick();
        check_id("t5_sat_hi", 32'h0000_0020, 1'b1);
        // one more not-taken -> 1, predicts not-taken
        bht_update_E = 1'b1;
        bht_pc_E     = 32'h0000_0020;
        bht_taken_E  = 1'b0;
        redirect_e(32'h0000_0020);
        idle();
        tick();
        check_id("t5_dec_lo", 32'h0000_0020, 1'b0);

        // T5b: 4 not-taken from reset saturate at 0
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        StallD       = 1'b1;
        bht_update_E = 1'b1;
        bht_pc_E     = 32'h0000_0020;
        bht_taken_E  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        StallD      = 1'b0;
        bht_taken_E = 1'b1;
        redirect_e(32'h0000_0020);
        // counter now 1; train again while fetching it: lookup sees old value
        tick();
        bht_update_E = 1'b0;
        check_id("t5_sat_lo_rw", 32'h0000_0020, 1'b0);
        redirect_e(32'h0000_0020);
        tick();
        check_id("t5_after_write", 32'h0000_0020, 1'b1);

        // PC wraps from 0xFFFF_FFFC to 0
        redirect_e(32'hFFFF_FFFC);
        tick();
        check("wrap_pcf", PCF, 32'd0);
        check("wrap_pcd", PCD, 32'hFFFF_FFFC);
        check("wrap_pc4d", PCPlus4D, 32'd0);

        // T6: imem not ready for 2 cycles, then reset in the middle of a stall
        redirect_e(32'h0000_0080);
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_wait_pcf", PCF, 32'h0000_0080);
            check_bubble("t6_wait");
        end
        imem_ready = 1'b1;
        tick();
        check("t6_resume_pcf", PCF, 32'h0000_0084);
        check_id("t6_resume", 32'h0000_0080, 1'b0);
        StallD       = 1'b1;
        imem_ready   = 1'b0;
        mispredict_E = 1'b1;
        correct_pc_E = 32'h0000_0500;
        rst          = 1'b1;
        tick();
        idle();
        check("t6_rst_pcf", PCF, 32'd0);
        check_bubble("t6_rst");
        for (int i = 0; i < 4; i++) tick();
        check_id("t6_bht_clr", 32'h0000_000C, 1'b0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
